// File: rtl/mult_array_pkg.sv
// Shared defaults and the per-stage control payload for the mult_array multiplier.
// The control payload travels down the pipe beside each lane's product registers.
package mult_array_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int CHANNELS_DEF = 3;
  localparam int STAGES_DEF   = 2;
  localparam int GUARD_DEF    = 4;

  typedef struct packed {
    logic vld;
    logic sgn;
    logic last;
  } stage_ctl_t;

endpackage

// File: rtl/mult_lane.sv
// One lane of mult_array: operand extension, full-width multiply, product stages, and the
// per-lane accumulator when MULT_ARRAY_ACC_EN is defined.
module mult_lane
  import mult_array_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int PW     = 2*WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_sgn,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_acc_vld,
  input  logic             i_acc_sgn,
  input  logic             i_acc_last,
  output logic [PW-1:0]    o_p
);

  localparam int FW = 2*WIDTH + 2;

  // One extra bit lets a single signed multiplier serve both operand modes.
  function automatic logic signed [WIDTH:0] ext_op(input logic [WIDTH-1:0] v, input logic sgn);
    return $signed({sgn & v[WIDTH-1], v});
  endfunction

  logic signed [FW-1:0]      w_ea;
  logic signed [FW-1:0]      w_eb;
  logic signed [FW-1:0]      w_full;
  logic signed [2*WIDTH-1:0] r_prod_p [STAGES];

  assign w_ea   = FW'(ext_op(i_a, i_sgn));
  assign w_eb   = FW'(ext_op(i_b, i_sgn));
  assign w_full = w_ea * w_eb;

  // Stage 0 captures the product; later stages shift on the shared advance enable.
  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_prod_p[0] <= w_full[2*WIDTH-1:0];
      for (int s = 1; s < STAGES; s++) r_prod_p[s] <= r_prod_p[s-1];
    end
    if (rst) r_prod_p[STAGES-1] <= '0;
  end

`ifdef MULT_ARRAY_ACC_EN
  function automatic logic [PW-1:0] ext_prod(input logic [2*WIDTH-1:0] p, input logic sgn);
    return {{(PW-2*WIDTH){sgn & p[2*WIDTH-1]}}, p};
  endfunction

  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_out;
  logic [PW-1:0] w_sum;
  logic          w_unused;

  assign w_sum    = r_acc + ext_prod(r_prod_p[STAGES-1], i_acc_sgn);
  assign w_unused = ^w_full[FW-1:2*WIDTH];

  // Accumulator stage: a frame's last beat emits acc+product and restarts the sum at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_adv && i_acc_vld) begin
      if (i_acc_last) begin
        r_out <= w_sum;
        r_acc <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

  assign o_p = r_out;
`else
  logic w_unused;

  assign w_unused = ^{w_full[FW-1:2*WIDTH], i_acc_vld, i_acc_sgn, i_acc_last};
  assign o_p      = r_prod_p[STAGES-1];
`endif

endmodule

// File: rtl/mult_array.sv
// Pipelined CHANNELS-lane multiplier on one valid/ready stream with per-beat signedness.
// Define MULT_ARRAY_ACC_EN to add per-lane accumulation with in_last frame delimiting.
module mult_array
  import mult_array_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int STAGES   = STAGES_DEF,
  parameter int GUARD    = GUARD_DEF,
`ifdef MULT_ARRAY_ACC_EN
  localparam int PW      = 2*WIDTH + GUARD
`else
  localparam int PW      = 2*WIDTH
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_a,
  input  logic [CHANNELS*WIDTH-1:0] in_b,
  input  logic                      in_signed,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*PW-1:0]    out_p
);

  stage_ctl_t r_ctl_p [STAGES];
  logic       w_stall;
  logic       w_adv;

  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = !rst && !w_stall;

  // Control stages: an unaccepted cycle enters as a bubble, nothing is compacted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) r_ctl_p[s] <= '0;
    end else if (w_adv) begin
      r_ctl_p[0] <= '{vld: in_valid, sgn: in_signed, last: in_last};
      for (int s = 1; s < STAGES; s++) r_ctl_p[s] <= r_ctl_p[s-1];
    end
  end

`ifdef MULT_ARRAY_ACC_EN
  logic r_out_vld;

  // Only a frame's last beat produces an output beat.
  always_ff @(posedge clk) begin
    if (rst) r_out_vld <= 1'b0;
    else if (w_adv) r_out_vld <= r_ctl_p[STAGES-1].vld && r_ctl_p[STAGES-1].last;
  end

  assign out_valid = r_out_vld;
`else
  logic w_unused;

  assign w_unused  = ^{r_ctl_p[STAGES-1].sgn, r_ctl_p[STAGES-1].last, 32'(GUARD)};
  assign out_valid = r_ctl_p[STAGES-1].vld;
`endif

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    mult_lane #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .PW    (PW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_adv     (w_adv),
      .i_sgn     (in_signed),
      .i_a       (in_a[ch*WIDTH +: WIDTH]),
      .i_b       (in_b[ch*WIDTH +: WIDTH]),
      .i_acc_vld (r_ctl_p[STAGES-1].vld),
      .i_acc_sgn (r_ctl_p[STAGES-1].sgn),
      .i_acc_last(r_ctl_p[STAGES-1].last),
      .o_p       (out_p[ch*PW +: PW])
    );
  end

endmodule
